systolic_array_sequencer: RTL and testbench
===========================================

# systolic_array_sequencer

Initiator-side controller for the weight-stationary `systolic_array`. It accepts weight tiles and feature vectors over valid/ready streams and drives the array's `load_weight`, `weight_in` and `feature_in`, skewing feature rows on the way in. It de-skews `result_out` columns into aligned result vectors and buffers them behind a valid/ready output. The array itself cannot stall, so the block throttles feature issue with output-buffer credits.

## Interface
- `WIDTH`, 32, element width; must equal the array's `WIDTH`.
- `M_SIZE`, 16, array dimension; must equal the array's `M_SIZE`.
- `OUT_DEPTH`, 33, result FIFO depth in vectors. Full rate needs ≥ 2·M_SIZE+1.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `w_valid`/`w_ready` in/out 1: weight beat handshake.
- `w_data` in WIDTH·M_SIZE: one weight column per beat; element r = W[r][col].
- `f_valid`/`f_ready` in/out 1: feature vector handshake.
- `f_data` in WIDTH·M_SIZE: element r = x[r].
- `f_last` in 1: marks the last vector of the current tile.
- `r_valid`/`r_ready` out/in 1: result handshake.
- `r_data` out WIDTH·M_SIZE: element c = y[c] = Σr W[r][c]·x[r], mod 2^WIDTH.
- `r_last` out 1: asserted with the result of the `f_last` vector.
- `sa_load_weight` out 1: to the array's `load_weight`.
- `sa_weight_in` out WIDTH·M_SIZE: to the array's `weight_in`.
- `sa_feature_in` out WIDTH·M_SIZE: to the array's `feature_in`.
- `sa_result_out` in WIDTH·M_SIZE: from the array's `result_out`.
- `busy` out 1: high when state ≠ LOAD or pending ≠ 0.

## Operation
- FSM states are LOAD, COMPUTE and DRAIN. Reset state is LOAD.
- **LOAD:**
  - `w_ready` = 1.
  - `sa_load_weight` = `w_valid`, combinational.
  - `sa_weight_in` = `w_data`, combinational passthrough.
  - Beat k (0..M_SIZE-1) carries column M_SIZE-1-k, so column M_SIZE-1 is sent first.
  - Gaps between beats are allowed.
  - Beat counter reaching M_SIZE → COMPUTE.
  - `f_ready` = 0.
- **COMPUTE:**
  - `f_ready` = (pending < OUT_DEPTH).
  - Each accepted vector enters the feature skew lines. Row r is delayed r+1 registers.
  - A tag (valid, last) enters a 2·M_SIZE-deep pipeline.
  - Non-issue cycles shift zeros into both.
  - Accepted `f_last` → DRAIN.
- **DRAIN:**
  - `f_ready` = 0 and `w_ready` = 0.
  - Exit to LOAD the cycle after the last tag is written into the FIFO. This ensures the array and skew lines hold zeros before `load_weight`, which clears the array's in-flight state.
- **De-skew:**
  - Column c of `sa_result_out` is delayed M_SIZE-1-c registers.
  - An aligned vector plus `r_last` is pushed into the FIFO when the tag at the pipeline end is valid.
- **Credits:**
  - pending = vectors accepted but not yet popped.
  - Increment on f accept, decrement on r pop; simultaneous accept and pop leaves it unchanged.
  - Credits guarantee the FIFO never overflows, so there is no drop path.
- Inputs offered in the wrong state are ignored: `f_valid` in LOAD and `w_valid` in COMPUTE/DRAIN.
- Arithmetic wraps mod 2^WIDTH inside the array. The block passes results through unmodified.

## Timing
- Latency: acceptance in cycle a → the vector's row 0 is on `sa_feature_in` in cycle a+1.
- Column c appears on `sa_result_out` in cycle a+1+M_SIZE+c.
- FIFO write is at the end of cycle a+2·M_SIZE. `r_valid` rises in cycle a+2·M_SIZE+1 if the FIFO was empty.
- Throughput: one vector per cycle while pending < OUT_DEPTH.
- DRAIN lasts exactly 2·M_SIZE cycles after the `f_last` acceptance cycle.
- Reset values, effective immediately on `rst_n` low:
  - `w_ready` = 1, `f_ready` = 0, `r_valid` = 0, `r_last` = 0, `r_data` = 0, `sa_feature_in` = 0, `busy` = 0.
  - `sa_load_weight` follows `w_valid`.
- Reset mid-operation discards skew lines, tags, FIFO contents, pending count and the beat counter. The weight tile must be reloaded.
- `r_data`/`r_last` are held stable while `r_valid` && !`r_ready`.

## Configuration
- Macro: `SA_SEQ_PERF_EN`.
- Defined: adds outputs `perf_tiles[31:0]` and `perf_stalls[31:0]`.
  - `perf_tiles` counts `f_last` acceptances.
  - `perf_stalls` counts COMPUTE cycles with `f_valid` && !`f_ready`.
  - Both saturate at all-ones and reset to 0.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- Package `systolic_pkg` holds:
  - the state enum (ST_LOAD, ST_COMPUTE, ST_DRAIN);
  - localparam function `sa_latency(M) = 2*M+1`.
- Sub-module `sa_result_fifo`: synchronous FIFO of width WIDTH·M_SIZE+1 and depth OUT_DEPTH, with show-ahead output.

## Test plan
All scenarios use M_SIZE=2, WIDTH=16, OUT_DEPTH=4 unless stated; W[r][c] = [[1,2],[3,4]].
- **Basic tile:** weight beats (2,4) then (1,3); feature (5,6) with `f_last` → `r_data`=(23,34), `r_last`=1. `r_valid` rises exactly 5 cycles after the accept cycle.
- **Back-to-back:** features (5,6),(1,0),(0,1) on consecutive cycles, `r_ready`=1 → results (23,34),(1,2),(3,4) on consecutive cycles; `f_ready` stays high throughout.
- **Backpressure:** `r_ready`=0, 6 vectors offered → `f_ready` drops after 4 accepts. With `r_ready`=1 one vector is accepted per pop; order is preserved and nothing is lost.
- **Tile switch:**
  - After `f_last`, `w_ready` = 0 for exactly 4 cycles.
  - Then load identity beats (0,1),(1,0) and feed (7,9) → result (7,9).
  - Older FIFO results are delivered first, with `r_last` only on each tile's final result.
- **Wrap:** WIDTH=8, all weights 16, x=(16,1) → y=(16,16), i.e. 272 mod 256.
- **Reset mid-COMPUTE:** assert `rst_n` low with 2 vectors in flight → `r_valid`=0, `w_ready`=1, `busy`=0, no results after release, perf counters = 0.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the weight-stationary systolic array sequencer.
`default_nettype none

package systolic_pkg;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DRAIN   = 2'd2
    } sa_state_t;

    // Accept-to-FIFO-visible latency of one vector through skew, array and de-skew.
    function automatic int sa_latency(input int m);
        return 2 * m + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sa_result_fifo.sv
// Synchronous show-ahead FIFO holding de-skewed result vectors and their last flag.
`default_nettype none

module sa_result_fifo
    import systolic_pkg::*;
#(
    parameter int DATA_W = 513,
    parameter int DEPTH  = 33
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign full      = (count == CW'(DEPTH));
    assign out_valid = (count != '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && out_valid;

    // Empty FIFO presents zeros so the output is clean out of reset without clearing storage.
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/systolic_array_sequencer.sv
// Feeds a weight-stationary systolic array: weight load, skewed feature issue, result de-skew.
// Optional SA_SEQ_PERF_EN adds saturating tile and stall counters.
`default_nettype none

module systolic_array_sequencer
    import systolic_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int M_SIZE    = 16,
    parameter int OUT_DEPTH = 33
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      w_valid,
    output logic                      w_ready,
    input  logic [WIDTH*M_SIZE-1:0]   w_data,
    input  logic                      f_valid,
    output logic                      f_ready,
    input  logic [WIDTH*M_SIZE-1:0]   f_data,
    input  logic                      f_last,
    output logic                      r_valid,
    input  logic                      r_ready,
    output logic [WIDTH*M_SIZE-1:0]   r_data,
    output logic                      r_last,
    output logic                      sa_load_weight,
    output logic [WIDTH*M_SIZE-1:0]   sa_weight_in,
    output logic [WIDTH*M_SIZE-1:0]   sa_feature_in,
    input  logic [WIDTH*M_SIZE-1:0]   sa_result_out,
    output logic                      busy
`ifdef SA_SEQ_PERF_EN
    ,
    output logic [31:0]               perf_tiles,
    output logic [31:0]               perf_stalls
`endif
);

    localparam int VW        = WIDTH * M_SIZE;
    localparam int TAG_DEPTH = sa_latency(M_SIZE) - 1;
    localparam int CNT_W     = $clog2(OUT_DEPTH + 1);
    localparam int BEAT_W    = $clog2(M_SIZE + 1);

    sa_state_t          state;
    sa_state_t          next_state;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [CNT_W-1:0]   pending;
    logic               has_credit;
    logic               f_accept;
    logic               r_pop;
    logic [TAG_DEPTH-1:0] tag_valid;
    logic [TAG_DEPTH-1:0] tag_last;
    logic [VW-1:0]      aligned;
    logic               fifo_push;
    logic [VW:0]        fifo_out;

    assign has_credit   = (pending < CNT_W'(OUT_DEPTH));
    assign f_accept     = f_valid && f_ready;
    assign r_pop        = r_valid && r_ready;
    assign sa_weight_in = w_data;
    assign busy         = (state != ST_LOAD) || (pending != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LOAD;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state     = state;
        w_ready        = 1'b0;
        f_ready        = 1'b0;
        sa_load_weight = 1'b0;
        case (state)
            ST_LOAD: begin
                w_ready        = 1'b1;
                sa_load_weight = w_valid;
                if (w_valid && (beat_cnt == BEAT_W'(M_SIZE - 1))) begin
                    next_state = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                f_ready = has_credit;
                if (f_valid && has_credit && f_last) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The tile's final tag reaching the FIFO means skew lines and array hold only zeros.
                if (tag_valid[TAG_DEPTH-1] && tag_last[TAG_DEPTH-1]) begin
                    next_state = ST_LOAD;
                end
            end
            default: next_state = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (state == ST_LOAD && w_valid) begin
            beat_cnt <= (beat_cnt == BEAT_W'(M_SIZE - 1)) ? '0 : beat_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            case ({f_accept, r_pop})
                2'b10:   pending <= pending + 1'b1;
                2'b01:   pending <= pending - 1'b1;
                default: pending <= pending;
            endcase
        end
    end

    // Row r sees the vector r+1 cycles after acceptance; idle cycles inject zeros.
    genvar gr;
    generate
        for (gr = 0; gr < M_SIZE; gr++) begin : g_skew
            logic [WIDTH-1:0] line [0:gr];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k <= gr; k++) begin
                        line[k] <= '0;
                    end
                end else begin
                    line[0] <= f_accept ? f_data[gr*WIDTH +: WIDTH] : '0;
                    for (int k = 1; k <= gr; k++) begin
                        line[k] <= line[k-1];
                    end
                end
            end
            assign sa_feature_in[gr*WIDTH +: WIDTH] = line[gr];
        end
    endgenerate

    // Column c leaves the array c cycles after column 0; delay it so all columns line up.
    genvar gc;
    generate
        for (gc = 0; gc < M_SIZE; gc++) begin : g_deskew
            localparam int DLY = M_SIZE - 1 - gc;
            if (DLY == 0) begin : g_direct
                assign aligned[gc*WIDTH +: WIDTH] = sa_result_out[gc*WIDTH +: WIDTH];
            end else begin : g_delay
                logic [WIDTH-1:0] dl [0:DLY-1];
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        for (int k = 0; k < DLY; k++) begin
                            dl[k] <= '0;
                        end
                    end else begin
                        dl[0] <= sa_result_out[gc*WIDTH +: WIDTH];
                        for (int k = 1; k < DLY; k++) begin
                            dl[k] <= dl[k-1];
                        end
                    end
                end
                assign aligned[gc*WIDTH +: WIDTH] = dl[DLY-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid <= '0;
            tag_last  <= '0;
        end else begin
            tag_valid <= {tag_valid[TAG_DEPTH-2:0], f_accept};
            tag_last  <= {tag_last[TAG_DEPTH-2:0], f_accept && f_last};
        end
    end

    assign fifo_push = tag_valid[TAG_DEPTH-1];

    sa_result_fifo #(
        .DATA_W (VW + 1),
        .DEPTH  (OUT_DEPTH)
    ) u_result_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data ({tag_last[TAG_DEPTH-1], aligned}),
        .pop       (r_pop),
        .out_valid (r_valid),
        .out_data  (fifo_out)
    );

    assign r_data = fifo_out[VW-1:0];
    assign r_last = fifo_out[VW];

`ifdef SA_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_tiles  <= '0;
            perf_stalls <= '0;
        end else begin
            if (f_accept && f_last && (perf_tiles != '1)) begin
                perf_tiles <= perf_tiles + 1'b1;
            end
            if ((state == ST_COMPUTE) && f_valid && !f_ready && (perf_stalls != '1)) begin
                perf_stalls <= perf_stalls + 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_systolic_array_sequencer.sv
// Bench for systolic_array_sequencer with a behavioural array model and result scoreboard.
`default_nettype none
`timescale 1ns/1ps

module tb_systolic_array_sequencer;

    localparam int W  = 16;
    localparam int M  = 2;
    localparam int D  = 4;
    localparam int VW = W * M;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          w_valid, w_ready;
    logic [VW-1:0] w_data;
    logic          f_valid, f_ready, f_last;
    logic [VW-1:0] f_data;
    logic          r_valid, r_ready, r_last;
    logic [VW-1:0] r_data;
    logic          sa_load_weight;
    logic [VW-1:0] sa_weight_in, sa_feature_in;
    logic [VW-1:0] sa_result_out = '0;
    logic          busy;
`ifdef SA_SEQ_PERF_EN
    logic [31:0]   perf_tiles, perf_stalls;
`endif

    always #5 clk = ~clk;

    systolic_array_sequencer #(.WIDTH(W), .M_SIZE(M), .OUT_DEPTH(D)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .w_valid        (w_valid),
        .w_ready        (w_ready),
        .w_data         (w_data),
        .f_valid        (f_valid),
        .f_ready        (f_ready),
        .f_data         (f_data),
        .f_last         (f_last),
        .r_valid        (r_valid),
        .r_ready        (r_ready),
        .r_data         (r_data),
        .r_last         (r_last),
        .sa_load_weight (sa_load_weight),
        .sa_weight_in   (sa_weight_in),
        .sa_feature_in  (sa_feature_in),
        .sa_result_out  (sa_result_out),
        .busy           (busy)
`ifdef SA_SEQ_PERF_EN
        ,
        .perf_tiles     (perf_tiles),
        .perf_stalls    (perf_stalls)
`endif
    );

    typedef struct {
        int x0, x1;
        bit last;
        int y0, y1;
    } vec_t;

    typedef struct {
        logic [W-1:0] y0, y1;
        logic         last;
    } res_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 8;
    res_t exp_q[$];
    int   pop_cyc[$];
    int   tw [0:M-1][0:M-1];

    // Array model: weights shift in from column 0; x[r] entering in cycle t contributes to
    // column c in cycle t + M + c - r.
    logic [W-1:0] aw   [0:M-1][0:M-1];
    logic [W-1:0] hist [0:7][0:M-1];
    logic [W-1:0] acc;
    logic         hold_v = 1'b0;
    logic [VW-1:0] hold_d;
    logic         hold_l;
    res_t         e;

    initial begin
        for (int r = 0; r < M; r++) begin
            for (int c = 0; c < M; c++) aw[r][c] = '0;
        end
        for (int t = 0; t < 8; t++) begin
            for (int r = 0; r < M; r++) hist[t][r] = '0;
        end
    end

    always @(posedge clk) begin
        if (sa_load_weight) begin
            for (int r = 0; r < M; r++) begin
                for (int c = M - 1; c > 0; c--) aw[r][c] <= aw[r][c-1];
                aw[r][0] <= sa_weight_in[r*W +: W];
            end
        end
    end

    always @(negedge clk) begin
        cyc++;
        for (int r = 0; r < M; r++) hist[cyc % 8][r] = sa_feature_in[r*W +: W];
        for (int c = 0; c < M; c++) begin
            acc = '0;
            for (int r = 0; r < M; r++) acc = acc + aw[r][c] * hist[(cyc - (M + c - r)) % 8][r];
            sa_result_out[c*W +: W] = acc;
        end
        if (hold_v && rst_n) begin
            checks++;
            if (!r_valid || r_data !== hold_d || r_last !== hold_l) begin
                errors++;
                $display("FAIL hold_stable got v=%0d d=%h l=%0d required v=1 d=%h l=%0d",
                         r_valid, r_data, r_last, hold_d, hold_l);
            end
        end
        hold_v = r_valid && !r_ready;
        hold_d = r_data;
        hold_l = r_last;
        if (r_valid && r_ready) begin
            checks++;
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result got y=(%0d,%0d) last=%0d required none",
                         r_data[W-1:0], r_data[2*W-1:W], r_last);
            end else begin
                e = exp_q.pop_front();
                if (r_data !== {e.y1, e.y0} || r_last !== e.last) begin
                    errors++;
                    $display("FAIL result got y=(%0d,%0d) last=%0d required y=(%0d,%0d) last=%0d",
                             r_data[W-1:0], r_data[2*W-1:W], r_last, e.y0, e.y1, e.last);
                end
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_y(input int c, input int x0, input int x1);
        longint s;
        s = longint'(tw[0][c]) * x0 + longint'(tw[1][c]) * x1;
        return int'(s % 65536);
    endfunction

    task automatic load_tile(input int w00, input int w01, input int w10, input int w11);
        int n;
        tw[0][0] = w00; tw[0][1] = w01; tw[1][0] = w10; tw[1][1] = w11;
        for (int k = 0; k < M; k++) begin
            w_valid = 1'b1;
            for (int r = 0; r < M; r++) w_data[r*W +: W] = W'(tw[r][M-1-k]);
            n = 0;
            while (!w_ready && n < 100) begin
                step();
                n++;
            end
            chk("load_w_ready", w_ready, 1);
            step();
        end
        w_valid = 1'b0;
    endtask

    task automatic send(input int x0, input int x1, input bit last, input int y0, input int y1,
                        input int budget, input bit rnd_rdy, output bit ok);
        res_t t;
        f_valid = 1'b1;
        f_data  = {W'(x1), W'(x0)};
        f_last  = last;
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            if (rnd_rdy) r_ready = ($urandom_range(0, 3) != 0);
            if (f_ready) ok = 1'b1;
            step();
        end
        f_valid = 1'b0;
        f_last  = 1'b0;
        if (ok) begin
            t.y0 = W'(y0); t.y1 = W'(y1); t.last = last;
            exp_q.push_back(t);
        end
    endtask

    task automatic wait_drain();
        r_ready = 1'b1;
        for (int n = 0; n < 300 && exp_q.size() != 0; n++) step();
        step();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    vec_t tbl [0:13];
    bit   ok;
    int   first_rv, wlow, i, x0, x1, nv;

    initial begin
        tbl[0]  = '{5, 6, 1, 23, 34};
        tbl[1]  = '{5, 6, 0, 23, 34};
        tbl[2]  = '{1, 0, 0, 1, 2};
        tbl[3]  = '{0, 1, 1, 3, 4};
        tbl[4]  = '{1, 1, 0, 4, 6};
        tbl[5]  = '{2, 0, 0, 2, 4};
        tbl[6]  = '{0, 3, 0, 9, 12};
        tbl[7]  = '{1, 2, 0, 7, 10};
        tbl[8]  = '{3, 1, 0, 6, 10};
        tbl[9]  = '{2, 2, 1, 8, 12};
        tbl[10] = '{7, 9, 1, 7, 9};
        tbl[11] = '{256, 1, 1, 256, 256};
        tbl[12] = '{5, 6, 0, 23, 34};
        tbl[13] = '{1, 0, 1, 1, 2};

        w_valid = 0; w_data = '0; f_valid = 0; f_data = '0; f_last = 0; r_ready = 0;
        repeat (3) step();
        chk("reset_w_ready", w_ready, 1);
        chk("reset_f_ready", f_ready, 0);
        chk("reset_r_valid", r_valid, 0);
        chk("reset_r_last", r_last, 0);
        chk("reset_r_data", r_data, 0);
        chk("reset_feature", sa_feature_in, 0);
        chk("reset_busy", busy, 0);
        w_valid = 1'b1;
        #1;
        chk("reset_load_follows", sa_load_weight, 1);
        w_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        step();

        // Basic tile: latency and DRAIN length
        load_tile(1, 2, 3, 4);
        send(tbl[0].x0, tbl[0].x1, tbl[0].last, tbl[0].y0, tbl[0].y1, 10, 0, ok);
        chk("basic_accept", ok, 1);
        first_rv = 0; wlow = 0;
        for (int k = 1; k <= 8; k++) begin
            if (first_rv == 0 && r_valid) first_rv = k;
            if (!w_ready) wlow++;
            step();
        end
        chk("basic_latency", first_rv, 5);
        chk("basic_drain_cycles", wlow, 4);
        wait_drain();

        // Back-to-back issue with r_ready high
        load_tile(1, 2, 3, 4);
        r_ready = 1'b1;
        pop_cyc.delete();
        for (int k = 1; k <= 3; k++) begin
            chk("b2b_f_ready", f_ready, 1);
            send(tbl[k].x0, tbl[k].x1, tbl[k].last, tbl[k].y0, tbl[k].y1, 1, 0, ok);
            chk("b2b_accept", ok, 1);
        end
        wait_drain();
        chk("b2b_pops", pop_cyc.size(), 3);
        if (pop_cyc.size() >= 3) chk("b2b_consecutive", pop_cyc[2] - pop_cyc[0], 2);

        // Backpressure: credits stop issue after OUT_DEPTH vectors
        load_tile(1, 2, 3, 4);
        r_ready = 1'b0;
        i = 4;
        ok = 1'b1;
        while (i <= 9 && ok) begin
            send(tbl[i].x0, tbl[i].x1, tbl[i].last, tbl[i].y0, tbl[i].y1, 8, 0, ok);
            if (ok) i++;
        end
        chk("bp_accepts", i - 4, 4);
        chk("bp_f_ready_low", f_ready, 0);
        chk("bp_busy", busy, 1);
        r_ready = 1'b1;
        for (; i <= 9; i++) begin
            send(tbl[i].x0, tbl[i].x1, tbl[i].last, tbl[i].y0, tbl[i].y1, 20, 0, ok);
            chk("bp_resume_accept", ok, 1);
        end
        wait_drain();

        // Tile switch with older results still queued
        load_tile(1, 2, 3, 4);
        r_ready = 1'b0;
        for (int k = 12; k <= 13; k++) begin
            send(tbl[k].x0, tbl[k].x1, tbl[k].last, tbl[k].y0, tbl[k].y1, 10, 0, ok);
            chk("switch_accept", ok, 1);
        end
        wlow = 0;
        for (int k = 1; k <= 8; k++) begin
            if (!w_ready) wlow++;
            step();
        end
        chk("switch_w_ready_low", wlow, 4);
        load_tile(1, 0, 0, 1);
        send(tbl[10].x0, tbl[10].x1, tbl[10].last, tbl[10].y0, tbl[10].y1, 10, 0, ok);
        chk("switch_ident_accept", ok, 1);
        chk("switch_queued", exp_q.size(), 3);
        wait_drain();

        // Wrap-around passes through unmodified
        load_tile(256, 256, 256, 256);
        send(tbl[11].x0, tbl[11].x1, tbl[11].last, tbl[11].y0, tbl[11].y1, 10, 0, ok);
        chk("wrap_accept", ok, 1);
        wait_drain();

        // Randomized tiles against the arithmetic reference
        for (int t = 0; t < 3; t++) begin
            load_tile($urandom_range(0, 65535), $urandom_range(0, 65535),
                      $urandom_range(0, 65535), $urandom_range(0, 65535));
            nv = $urandom_range(4, 12);
            for (int k = 0; k < nv; k++) begin
                x0 = $urandom_range(0, 65535);
                x1 = $urandom_range(0, 65535);
                if ($urandom_range(0, 3) == 0) step();
                send(x0, x1, (k == nv - 1), ref_y(0, x0, x1), ref_y(1, x0, x1), 200, 1, ok);
                chk("rand_accept", ok, 1);
            end
        end
        wait_drain();

        // Reset with vectors in flight
        load_tile(1, 2, 3, 4);
        r_ready = 1'b0;
        send(5, 6, 0, 23, 34, 10, 0, ok);
        send(1, 0, 0, 1, 2, 10, 0, ok);
        exp_q.delete();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_r_valid", r_valid, 0);
        chk("mid_reset_w_ready", w_ready, 1);
        chk("mid_reset_busy", busy, 0);
        chk("mid_reset_f_ready", f_ready, 0);
        chk("mid_reset_feature", sa_feature_in, 0);
`ifdef SA_SEQ_PERF_EN
        chk("mid_reset_perf_tiles", perf_tiles, 0);
        chk("mid_reset_perf_stalls", perf_stalls, 0);
`endif
        step();
        rst_n = 1'b1;
        r_ready = 1'b1;
        pop_cyc.delete();
        repeat (12) step();
        chk("post_reset_no_results", pop_cyc.size(), 0);
        chk("post_reset_idle_busy", busy, 0);

        load_tile(1, 2, 3, 4);
        send(tbl[0].x0, tbl[0].x1, tbl[0].last, tbl[0].y0, tbl[0].y1, 10, 0, ok);
        chk("post_reset_accept", ok, 1);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout actual running required finished");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
